// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: mode encodings, counter direction
// and the terminal-count test used by the period counter.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  // P==2 in center mode never counts down, so its top value is also the terminal.
  function automatic logic is_tc(input logic [31:0] cnt, input logic down,
                                 input logic [31:0] per, input logic mode);
    if (per <= 32'd1) return 1'b1;
    if (mode == MODE_EDGE) return cnt == per - 32'd1;
    return (cnt == 32'd1) && (down || per == 32'd2);
  endfunction

endpackage

// File: rtl/pwm_ch.sv
// One PWM channel: compare against the shared count, apply polarity, register.
module pwm_ch #(
  parameter int A = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         enable_i,
  input  logic [A-1:0] cnt_i,
  input  logic [A-1:0] duty_i,
  input  logic         pol_i,
  output logic         pwm_o
);

  logic pwm_d, pwm_q;

  // Idle level is the polarity alone, i.e. the inactive level of the channel.
  always_comb begin
    pwm_d = pol_i;
    if (enable_i) pwm_d = (cnt_i < duty_i) ^ pol_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pwm_q <= 1'b0;
    else         pwm_q <= pwm_d;
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM with a shared edge/center-aligned counter and double-buffered
// configuration that is applied only at period boundaries or while idle.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int A = 8,
  parameter int N = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           enable_i,
  input  logic           cfg_load_i,
  input  logic [A-1:0]   cfg_period_i,
  input  logic [N*A-1:0] cfg_duty_i,
  input  logic           cfg_mode_i,
  input  logic [N-1:0]   cfg_pol_i,
  output logic           cfg_pending_o,
  output logic           period_end_o,
  output logic [N-1:0]   pwm_out_o
);

  logic [A-1:0]   sh_per_q, act_per_q;
  logic [N*A-1:0] sh_duty_q, act_duty_q;
  logic           sh_mode_q, act_mode_q;
  logic [N-1:0]   sh_pol_q, act_pol_q;
  logic           pend_q, pend_d;
  logic [A-1:0]   cnt_q, cnt_d;
  dir_e           dir_q, dir_d;
  logic           pe_q;
  logic           bnd, apply;

  always_comb begin
    bnd   = enable_i && is_tc(32'(cnt_q), dir_q == DIR_DOWN, 32'(act_per_q), act_mode_q);
    // While idle there is no period to protect, so a pending shadow goes live at once.
    apply = pend_q && (bnd || !enable_i);
    pend_d = pend_q;
    if (cfg_load_i)  pend_d = 1'b1;
    else if (apply)  pend_d = 1'b0;

    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!enable_i || bnd) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (act_mode_q == MODE_EDGE) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dir_q == DIR_UP && cnt_q == act_per_q - 1'b1) begin
      cnt_d = cnt_q - 1'b1;
      dir_d = DIR_DOWN;
    end else if (dir_q == DIR_DOWN) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_per_q   <= '0;
      sh_duty_q  <= '0;
      sh_mode_q  <= MODE_EDGE;
      sh_pol_q   <= '0;
      act_per_q  <= '0;
      act_duty_q <= '0;
      act_mode_q <= MODE_EDGE;
      act_pol_q  <= '0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      dir_q      <= DIR_UP;
      pe_q       <= 1'b0;
    end else begin
      if (cfg_load_i) begin
        sh_per_q  <= cfg_period_i;
        sh_duty_q <= cfg_duty_i;
        sh_mode_q <= cfg_mode_i;
        sh_pol_q  <= cfg_pol_i;
      end
      if (apply) begin
        act_per_q  <= sh_per_q;
        act_duty_q <= sh_duty_q;
        act_mode_q <= sh_mode_q;
        act_pol_q  <= sh_pol_q;
      end
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      pe_q   <= bnd;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    pwm_ch #(.A(A)) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .enable_i (enable_i),
      .cnt_i    (cnt_q),
      .duty_i   (act_duty_q[i*A +: A]),
      .pol_i    (act_pol_q[i]),
      .pwm_o    (pwm_out_o[i])
    );
  end

  assign cfg_pending_o = pend_q;
  assign period_end_o  = pe_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a phase-based period model predicts every
// registered output one cycle ahead; predictions are queued and compared.
module tb_pwm_multi;
  localparam int A = 8;
  localparam int N = 4;

  logic           clk, rst_n, en, ld, mode;
  logic [A-1:0]   per;
  logic [N*A-1:0] duty;
  logic [N-1:0]   pol;
  logic           pend_o, pe_o;
  logic [N-1:0]   pwm_o;

  pwm_multi #(.A(A), .N(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .cfg_load_i(ld),
    .cfg_period_i(per), .cfg_duty_i(duty), .cfg_mode_i(mode), .cfg_pol_i(pol),
    .cfg_pending_o(pend_o), .period_end_o(pe_o), .pwm_out_o(pwm_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [N-1:0] pwm; logic pe; logic pend; } exp_t;
  exp_t q[$];
  int errs = 0, checks = 0;

  // model state
  int m_sh_p, m_act_p, m_ph;
  int m_sh_d[N], m_act_d[N];
  logic m_sh_mode, m_act_mode, m_pend;
  logic [N-1:0] m_sh_pol, m_act_pol;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int plen(input int p, input logic m);
    if (p <= 1) return 1;
    return (m == 1'b0) ? p : 2 * (p - 1);
  endfunction

  function automatic int pcnt(input int ph, input int p, input logic m);
    if (p <= 1) return 0;
    if (m == 1'b0 || ph < p) return ph;
    return 2 * (p - 1) - ph;
  endfunction

  task automatic model_reset();
    m_sh_p = 0; m_act_p = 0; m_ph = 0;
    m_sh_mode = 0; m_act_mode = 0; m_pend = 0;
    m_sh_pol = '0; m_act_pol = '0;
    for (int i = 0; i < N; i++) begin m_sh_d[i] = 0; m_act_d[i] = 0; end
  endtask

  task automatic step();
    exp_t e, g;
    int len, c;
    logic tc, apply;
    len = plen(m_act_p, m_act_mode);
    c   = pcnt(m_ph, m_act_p, m_act_mode);
    tc  = en && (m_ph == len - 1);
    for (int i = 0; i < N; i++)
      e.pwm[i] = en ? ((c < m_act_d[i]) ^ m_act_pol[i]) : m_act_pol[i];
    e.pe  = tc;
    apply = m_pend && (tc || !en);
    e.pend = ld ? 1'b1 : (apply ? 1'b0 : m_pend);
    q.push_back(e);
    if (apply) begin
      m_act_p = m_sh_p; m_act_mode = m_sh_mode; m_act_pol = m_sh_pol;
      for (int i = 0; i < N; i++) m_act_d[i] = m_sh_d[i];
    end
    if (ld) begin
      m_sh_p = int'(per); m_sh_mode = mode; m_sh_pol = pol;
      for (int i = 0; i < N; i++) m_sh_d[i] = int'(duty[i*A +: A]);
    end
    m_pend = e.pend;
    m_ph = (!en || tc) ? 0 : m_ph + 1;
    @(posedge clk); #1;
    g = q.pop_front();
    chk("pwm_out", 32'(pwm_o), 32'(g.pwm));
    chk("period_end", 32'(pe_o), 32'(g.pe));
    chk("cfg_pending", 32'(pend_o), 32'(g.pend));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load(input int p, input logic m, input int d0, input int d1,
                      input int d2, input int d3, input logic [N-1:0] pl);
    per = A'(p); mode = m; pol = pl;
    duty = {A'(d3), A'(d2), A'(d1), A'(d0)};
    ld = 1'b1; step(); ld = 1'b0;
  endtask

  task automatic run_to_ph(input int ph);
    for (int k = 0; k < 60 && m_ph != ph; k++) step();
    chk("reach_phase", 32'(m_ph), 32'(ph));
  endtask

  initial begin
    rst_n = 1'b0; en = 0; ld = 0; mode = 0; per = '0; duty = '0; pol = '0;
    model_reset();
    #12;
    chk("rst_pwm", 32'(pwm_o), 32'h0);
    chk("rst_pe", 32'(pe_o), 32'h0);
    chk("rst_pend", 32'(pend_o), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // edge mode P=10, duty {0,3,10,12}; loaded while idle so it applies at once
    load(10, 1'b0, 0, 3, 10, 12, 4'b0000);
    en = 1'b1;
    run(25);

    // center mode P=5, ch0 duty 2
    load(5, 1'b1, 2, 0, 5, 1, 4'b0000);
    run(24);

    // shadow update mid-period
    load(10, 1'b0, 3, 3, 3, 3, 4'b0000);
    for (int k = 0; k < 40 && m_pend; k++) step();
    run_to_ph(4);
    load(10, 1'b0, 7, 3, 3, 3, 4'b0000);
    run(25);

    // back-to-back loads, last one wins
    run_to_ph(2);
    load(10, 1'b0, 5, 5, 5, 5, 4'b0000);
    run(2);
    load(10, 1'b0, 6, 6, 6, 6, 4'b0000);
    run(15);
    // load on the terminal cycle: old shadow applies, pending stays set
    load(10, 1'b0, 2, 2, 2, 2, 4'b0000);
    run_to_ph(9);
    load(10, 1'b0, 8, 1, 1, 1, 4'b0000);
    chk("tc_load_pend", 32'(pend_o), 32'h1);
    run(22);

    // polarity while idle, then restart
    en = 1'b0;
    load(10, 1'b0, 4, 4, 4, 4, 4'b1010);
    run(2);
    chk("idle_pol", 32'(pwm_o), 32'hA);
    en = 1'b1;
    run(12);

    // async reset mid-period
    run_to_ph(5);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pwm", 32'(pwm_o), 32'h0);
    chk("arst_pend", 32'(pend_o), 32'h0);
    chk("arst_pe", 32'(pe_o), 32'h0);
    model_reset();
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    run(5);

    // degenerate periods: every cycle a boundary
    load(0, 1'b0, 1, 0, 200, 1, 4'b0000);
    run(6);
    load(1, 1'b1, 1, 1, 0, 255, 4'b0100);
    run(6);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
